// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, 8 data + odd parity + stop, ACK check.
// Optional macro PS2TX_GLITCH_FILTER_EN: a device clock fall needs 8 consecutive low samples.
module ps2_host_tx #(
    parameter int unsigned sysclk_frequency = 1250,
    parameter int unsigned inhibit_us       = 100,
    parameter int unsigned timeout_ms       = 15
) (
    input  logic       clk,
    input  logic       reset_in,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_error
);

    localparam int unsigned N_INH = sysclk_frequency * inhibit_us / 10;
    localparam int unsigned N_TO  = sysclk_frequency * timeout_ms * 100;
    localparam int unsigned N_MAX = (N_INH > N_TO) ? N_INH : N_TO;
    localparam int unsigned CW    = $clog2(N_MAX + 1);

    localparam logic [CW-1:0] INH_LAST = CW'(N_INH - 2);
    localparam logic [CW-1:0] TO_LAST  = CW'(N_TO - 1);
    localparam logic [CW-1:0] ONE      = CW'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_INH_REL,
        S_RTS,
        S_DATA,
        S_PARITY,
        S_ACK,
        S_WAIT_IDLE
    } state_t;

    state_t        state_q, state_d;
    logic [8:0]    shift_q, shift_d;
    logic [3:0]    bitcnt_q, bitcnt_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          clk_oe_q, clk_oe_d;
    logic          dat_oe_q, dat_oe_d;
    logic          nack_q, nack_d;
    logic          done_q, done_d;
    logic          error_q, error_d;

    logic clk_s1_q, clk_s2_q;
    logic dat_s1_q, dat_s2_q;
    logic fall;
    logic watching;
    logic timed_out;

    // Synchronisers reset to the idle (released) bus level so reset never looks like a fall.
    always_ff @(posedge clk or negedge reset_in) begin
        if (!reset_in) begin
            clk_s1_q <= 1'b1;
            clk_s2_q <= 1'b1;
            dat_s1_q <= 1'b1;
            dat_s2_q <= 1'b1;
        end else begin
            clk_s1_q <= ps2_clk_in;
            clk_s2_q <= clk_s1_q;
            dat_s1_q <= ps2_dat_in;
            dat_s2_q <= dat_s1_q;
        end
    end

`ifdef PS2TX_GLITCH_FILTER_EN
    logic [2:0] lo_cnt_q;
    logic       armed_q;

    always_ff @(posedge clk or negedge reset_in) begin
        if (!reset_in) begin
            lo_cnt_q <= '0;
            armed_q  <= 1'b0;
        end else if (clk_s2_q) begin
            lo_cnt_q <= '0;
            armed_q  <= 1'b1;
        end else if (armed_q) begin
            if (lo_cnt_q == 3'd7) begin
                armed_q <= 1'b0;
            end else begin
                lo_cnt_q <= lo_cnt_q + 3'd1;
            end
        end
    end

    assign fall = armed_q & ~clk_s2_q & (lo_cnt_q == 3'd7);
`else
    logic clk_prev_q;

    always_ff @(posedge clk or negedge reset_in) begin
        if (!reset_in) begin
            clk_prev_q <= 1'b1;
        end else begin
            clk_prev_q <= clk_s2_q;
        end
    end

    assign fall = clk_prev_q & ~clk_s2_q;
`endif

    always_ff @(posedge clk or negedge reset_in) begin
        if (!reset_in) begin
            state_q  <= S_IDLE;
            shift_q  <= '0;
            bitcnt_q <= '0;
            cnt_q    <= '0;
            clk_oe_q <= 1'b0;
            dat_oe_q <= 1'b0;
            nack_q   <= 1'b0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            bitcnt_q <= bitcnt_d;
            cnt_q    <= cnt_d;
            clk_oe_q <= clk_oe_d;
            dat_oe_q <= dat_oe_d;
            nack_q   <= nack_d;
            done_q   <= done_d;
            error_q  <= error_d;
        end
    end

    assign watching  = (state_q == S_RTS) || (state_q == S_DATA) || (state_q == S_PARITY) ||
                       (state_q == S_ACK) || (state_q == S_WAIT_IDLE);
    assign timed_out = !fall && (cnt_q == TO_LAST);

    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        bitcnt_d = bitcnt_q;
        cnt_d    = cnt_q;
        clk_oe_d = clk_oe_q;
        dat_oe_d = dat_oe_q;
        nack_d   = nack_q;
        done_d   = 1'b0;
        error_d  = 1'b0;

        if (watching) begin
            cnt_d = fall ? '0 : cnt_q + ONE;
        end

        unique case (state_q)
            S_IDLE: begin
                if (tx_valid) begin
                    shift_d  = {~^tx_data, tx_data};
                    bitcnt_d = '0;
                    cnt_d    = '0;
                    clk_oe_d = 1'b1;
                    dat_oe_d = 1'b0;
                    state_d  = S_INHIBIT;
                end
            end
            S_INHIBIT: begin
                dat_oe_d = 1'b0;
                if (cnt_q == INH_LAST) begin
                    dat_oe_d = 1'b1;
                    cnt_d    = '0;
                    state_d  = S_INH_REL;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            S_INH_REL: begin
                clk_oe_d = 1'b0;
                cnt_d    = '0;
                state_d  = S_RTS;
            end
            S_RTS, S_DATA: begin
                if (fall) begin
                    dat_oe_d = ~shift_q[0];
                    shift_d  = {1'b0, shift_q[8:1]};
                    bitcnt_d = bitcnt_q + 4'd1;
                    if (state_q == S_RTS) begin
                        state_d = S_DATA;
                    end else if (bitcnt_q == 4'd8) begin
                        state_d = S_PARITY;
                    end
                end
            end
            S_PARITY: begin
                if (fall) begin
                    dat_oe_d = 1'b0;
                    state_d  = S_ACK;
                end
            end
            S_ACK: begin
                if (fall) begin
                    nack_d  = dat_s2_q;
                    state_d = S_WAIT_IDLE;
                end
            end
            S_WAIT_IDLE: begin
                if (clk_s2_q && dat_s2_q) begin
                    done_d  = ~nack_q;
                    error_d = nack_q;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Timeout applies only when this cycle made no progress (no fall, no bus-idle completion).
        if (watching && timed_out && (state_d == state_q)) begin
            clk_oe_d = 1'b0;
            dat_oe_d = 1'b0;
            error_d  = 1'b1;
            done_d   = 1'b0;
            state_d  = S_IDLE;
        end
    end

    assign ps2_clk_oe = clk_oe_q;
    assign ps2_dat_oe = dat_oe_q;
    assign tx_ready   = (state_q == S_IDLE);
    assign busy       = (state_q != S_IDLE);
    assign tx_done    = done_q;
    assign tx_error   = error_q;

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- PS/2 host-to-device transmitter: sends one command byte (e.g. keyboard LED set 0xED, reset 0xFF) to the attached keyboard/mouse.
- Complements the existing PS/2 receive path, which is device-to-host only.
- Drives PS2_CLK/PS2_DAT as open-drain via output-enable lines; the toplevel ties each pad to low when its `_oe` is 1 and to Z otherwise.
- Sits beside the PS/2 receiver on the CPU peripheral bus. The CPU writes a byte and reads the done/error status.

Parameters:
- sysclk_frequency, 1250, system clock in units of 100 kHz; 1250 = 125 MHz.
- inhibit_us, 100, time the host holds the clock low before request-to-send, in µs.
- timeout_ms, 15, maximum wait for any device clock edge, in ms.

Ports:
- clk  in  1  system clock
- reset_in  in  1  asynchronous, active-low reset
- ps2_clk_in  in  1  raw PS2_CLK pad input (asynchronous)
- ps2_dat_in  in  1  raw PS2_DAT pad input (asynchronous)
- ps2_clk_oe  out  1  1 = pull PS2_CLK low
- ps2_dat_oe  out  1  1 = pull PS2_DAT low
- tx_data  in  8  byte to send
- tx_valid  in  1  request; the byte is accepted when tx_valid && tx_ready
- tx_ready  out  1  high only in IDLE
- busy  out  1  high in every state except IDLE; the receiver uses it to ignore the bus
- tx_done  out  1  one-cycle pulse: device acknowledged the byte
- tx_error  out  1  one-cycle pulse: no ACK, or timeout

Behaviour:
- Reset (async assert, sync release):
  - ps2_clk_oe=0, ps2_dat_oe=0, tx_ready=1, busy=0, tx_done=0, tx_error=0.
  - State IDLE; shift register, bit counter and timers cleared.
- Input handling:
  - ps2_clk_in and ps2_dat_in each pass through a 2-flop synchroniser.
  - A device falling edge (fall) is sync_clk going 1→0 between consecutive cycles.
- Timer constants:
  - inhibit count N_INH = sysclk_frequency*inhibit_us/10 cycles.
  - timeout count N_TO = sysclk_frequency*timeout_ms*100 cycles.
  - Counter width is derived with $clog2.
- State machine:
  - IDLE: on tx_valid, latch tx_data and compute odd parity p = ~^tx_data. Then set clk_oe=1 and go to INHIBIT. The cycle after acceptance has tx_ready=0 and busy=1.
  - INHIBIT: hold clk_oe=1 for N_INH cycles. Then set dat_oe=1 (start bit), then clk_oe=0 one cycle later, and go to RTS. The data line is asserted no later than the clock is released.
  - RTS: wait for a fall (device begins clocking). On fall 1, drive bit0: dat_oe = ~tx_data[0]. Bit count = 1; go to DATA.
  - DATA: on each fall n (n = 2..8), drive bit n-1, LSB first. On fall 9, drive parity: dat_oe = ~p; go to PARITY.
  - PARITY: on fall 10, dat_oe=0 (stop bit = released line); go to ACK.
  - ACK: on fall 11, sample sync_dat. A value of 0 means acknowledged, 1 means error. Go to WAIT_IDLE and remember the result.
  - WAIT_IDLE: wait until sync_clk=1 and sync_dat=1. Then pulse tx_done or tx_error for 1 cycle and return to IDLE. tx_ready rises on the same cycle as the pulse.
- Timeout:
  - In RTS, DATA, PARITY, ACK and WAIT_IDLE, a counter is cleared on every fall and increments otherwise.
  - On reaching N_TO: release both lines, pulse tx_error, return to IDLE.
  - If the timeout and a fall occur in the same cycle, the fall wins.
- Never both drive and release: while in INHIBIT, dat_oe=0. Once the bus has been released, neither line is driven low except as listed above.
- tx_valid is ignored outside IDLE; no queueing.
- tx_done and tx_error are never asserted together.
- reset_in asserted mid-transfer: lines are released immediately (async). No pulse is generated.

Optional Feature:
- Macro PS2TX_GLITCH_FILTER_EN.
- Defined:
  - A fall is recognised only after sync_clk has been 0 for 8 consecutive cycles following a 1.
  - Pulses low for less than 8 cycles are ignored; they neither advance the bit count nor reset the timeout.
  - This adds 7 cycles of edge latency.
- Undefined: a fall is a single-cycle 1→0 transition of sync_clk, as specified above.

Test Plan:
- Send 0xED: 0xED has six 1-bits, so odd parity p=1.
  - After reset, check ps2_clk_oe is held 1 for exactly 12500 cycles (sysclk_frequency=1250).
  - A device model clocks 11 falls at 12 kHz and samples on each rising edge.
  - Device must see start 0, data bits 1,0,1,1,0,1,1,1, parity 1, stop 1.
  - Device pulls data low on fall 11 → tx_done pulses once and tx_error stays 0.
- Send 0x00: parity bit must be 1; device sees all-zero data.
  - Device does not pull data low at fall 11 → tx_error pulses once, no tx_done.
- Send 0xFF: device never clocks after RTS.
  - At 1,875,000 idle cycles, tx_error pulses; both oe outputs drop to 0; tx_ready returns to 1.
- Assert tx_valid with 0x55 while busy (mid-DATA): the byte is ignored.
  - The in-flight byte completes unchanged; exactly one tx_done.
- Assert reset_in=0 at fall 5: ps2_clk_oe and ps2_dat_oe go to 0 in the same cycle. No tx_done/tx_error pulse. The next transfer after release completes normally.
- With PS2TX_GLITCH_FILTER_EN: inject a 3-cycle low glitch on PS2_CLK during DATA. The bit count does not advance, and the transfer completes with correct data.
